// File: rtl/boot_copy_seq_pkg.sv
// Shared types for the boot copy sequencer: FSM state encoding, also used by the bench for probes.
package boot_copy_seq_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRdReq  = 3'd1,
    StRdWait = 3'd2,
    StWr     = 3'd3,
    StHold   = 3'd4,
    StRun    = 3'd5,
    StErr    = 3'd6
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned words);
    return $clog2(words + 1);
  endfunction

endpackage

// File: rtl/boot_copy_seq_if.sv
// ROM read and SRAM write buses of the boot copy sequencer (IOb-native style).
interface boot_copy_seq_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned ROM_ADDR_W = 12
) ();
  logic                    rom_avalid;
  logic [ROM_ADDR_W-1:0]   rom_addr;
  logic                    rom_rvalid;
  logic [DATA_W-1:0]       rom_rdata;
  logic                    sram_avalid;
  logic [ADDR_W-1:0]       sram_addr;
  logic [DATA_W-1:0]       sram_wdata;
  logic [DATA_W/8-1:0]     sram_wstrb;
  logic                    sram_ready;

  modport master (
    output rom_avalid, rom_addr, sram_avalid, sram_addr, sram_wdata, sram_wstrb,
    input  rom_rvalid, rom_rdata, sram_ready
  );

  modport slave (
    input  rom_avalid, rom_addr, sram_avalid, sram_addr, sram_wdata, sram_wstrb,
    output rom_rvalid, rom_rdata, sram_ready
  );
endinterface

// File: rtl/boot_copy_hold_timer.sv
// Loadable down-counter timing how long the CPU is held in reset after the copy.
module boot_copy_hold_timer #(
  parameter int unsigned RST_HOLD = 100
) (
  input  logic clk_i,
  input  logic cke_i,
  input  logic arst_n_i,
  input  logic load_i,
  output logic done_o
);
  localparam int unsigned W = $clog2(RST_HOLD + 1);

  logic [W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = W'(RST_HOLD);
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      count_q <= '0;
    end else if (cke_i) begin
      count_q <= count_d;
    end
  end

  // Last hold cycle: the FSM leaves HOLD on the edge that ends it.
  assign done_o = (count_q == W'(1));
endmodule

// File: rtl/boot_copy_seq.sv
// Boot sequencer: copies the boot image from ROM to SRAM, then releases the CPU reset.
// Optional BOOT_COPY_CHECKSUM_EN adds an image checksum and an error state.
module boot_copy_seq
  import boot_copy_seq_pkg::*;
#(
  parameter int unsigned     DATA_W     = 32,
  parameter int unsigned     ADDR_W     = 32,
  parameter int unsigned     ROM_ADDR_W = 12,
  parameter int unsigned     BOOT_WORDS = 1024,
  parameter logic [ADDR_W-1:0] SRAM_BASE = '0,
  parameter int unsigned     RST_HOLD   = 100
) (
  input  logic               clk_i,
  input  logic               cke_i,
  input  logic               arst_n_i,
  input  logic               boot_i,
  input  logic               start_i,
  boot_copy_seq_if.master    mem,
  output logic               cpu_reset_o,
  output logic               busy_o,
  output logic               err_o
);
  localparam int unsigned CntW   = cnt_width(BOOT_WORDS);
  localparam int unsigned BytesW = DATA_W / 8;

  state_e              state_d, state_q;
  logic [CntW-1:0]     cnt_d, cnt_q;
  logic [DATA_W-1:0]   data_d, data_q;
  logic                cpu_reset_d, cpu_reset_q;
  logic                hold_load, hold_done;
`ifdef BOOT_COPY_CHECKSUM_EN
  logic [DATA_W-1:0]   sum_d, sum_q;
`endif

  boot_copy_hold_timer #(
    .RST_HOLD (RST_HOLD)
  ) u_hold_timer (
    .clk_i    (clk_i),
    .cke_i    (cke_i),
    .arst_n_i (arst_n_i),
    .load_i   (hold_load),
    .done_o   (hold_done)
  );

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      data_q      <= '0;
      cpu_reset_q <= 1'b1;
`ifdef BOOT_COPY_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else if (cke_i) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      cpu_reset_q <= cpu_reset_d;
`ifdef BOOT_COPY_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
`ifdef BOOT_COPY_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d   = '0;
`ifdef BOOT_COPY_CHECKSUM_EN
        sum_d   = '0;
`endif
        state_d = boot_i ? StRdReq : StHold;
      end
      StRdReq: state_d = StRdWait;
      StRdWait: begin
        if (mem.rom_rvalid) begin
          data_d  = mem.rom_rdata;
          state_d = StWr;
        end
      end
      StWr: begin
        if (mem.sram_ready) begin
          cnt_d = cnt_q + CntW'(1);
`ifdef BOOT_COPY_CHECKSUM_EN
          sum_d = sum_q + data_q;
`endif
          if (cnt_q == CntW'(BOOT_WORDS - 1)) begin
`ifdef BOOT_COPY_CHECKSUM_EN
            state_d = (sum_d != '0) ? StErr : StHold;
`else
            state_d = StHold;
`endif
          end else begin
            state_d = StRdReq;
          end
        end
      end
      StHold: begin
        if (hold_done) state_d = StRun;
      end
      StRun: begin
        if (start_i) state_d = StIdle;
      end
`ifdef BOOT_COPY_CHECKSUM_EN
      StErr: begin
        if (start_i) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Registered from the next state so the CPU reset never glitches.
  assign cpu_reset_d = (state_d != StRun);
  assign hold_load   = (state_d == StHold) && (state_q != StHold);

  always_comb begin
    mem.rom_avalid  = (state_q == StRdReq);
    mem.rom_addr    = ROM_ADDR_W'(cnt_q);
    mem.sram_avalid = (state_q == StWr);
    mem.sram_addr   = SRAM_BASE + ADDR_W'(cnt_q) * ADDR_W'(BytesW);
    mem.sram_wdata  = data_q;
    mem.sram_wstrb  = (state_q == StWr) ? '1 : '0;
    busy_o          = (state_q != StRun) && (state_q != StErr);
`ifdef BOOT_COPY_CHECKSUM_EN
    err_o           = (state_q == StErr);
`else
    err_o           = 1'b0;
`endif
    cpu_reset_o     = cpu_reset_q;
  end
endmodule

// File: tb/tb_boot_copy_seq.sv
// Directed bench for boot_copy_seq: ROM/SRAM models, write scoreboard, timing checks.
module tb_boot_copy_seq;
  import boot_copy_seq_pkg::*;

  localparam int unsigned DataW = 32;
  localparam int unsigned AddrW = 32;
  localparam int unsigned RomAW = 4;
  localparam int unsigned Words = 4;
  localparam int unsigned Hold  = 6;
  localparam logic [31:0] Base  = 32'h100;
`ifdef BOOT_COPY_CHECKSUM_EN
  localparam bit Cks = 1'b1;
`else
  localparam bit Cks = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          cyc;
  } wr_t;

  logic clk = 1'b0, cke = 1'b1, arst_n = 1'b0, boot = 1'b1, start = 1'b0;
  logic cpu_reset, busy, err;
  int   errors = 0, checks = 0;
  int   cyc = 0, rom_reqs = 0, sram_reqs = 0, stall_left = 5;
  bit   rom_err = 1'b0, stall_en = 1'b0;
  wr_t  obs_q[$], exp_q[$];

  boot_copy_seq_if #(.DATA_W(DataW), .ADDR_W(AddrW), .ROM_ADDR_W(RomAW)) bus ();

  boot_copy_seq #(
    .DATA_W(DataW), .ADDR_W(AddrW), .ROM_ADDR_W(RomAW), .BOOT_WORDS(Words),
    .SRAM_BASE(Base), .RST_HOLD(Hold)
  ) dut (
    .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n), .boot_i(boot), .start_i(start),
    .mem(bus), .cpu_reset_o(cpu_reset), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  // Image: 0xA0+addr; with the checksum build the last word balances the sum to 0 (or 1 if bad).
  function automatic logic [31:0] rom_word(input int a, input bit bad);
    if (Cks && a == int'(Words) - 1) return bad ? 32'hFFFF_FE1E : 32'hFFFF_FE1D;
    return 32'hA0 + 32'(a);
  endfunction

  always @(posedge clk) begin
    bus.rom_rvalid <= bus.rom_avalid;
    bus.rom_rdata  <= rom_word(int'(bus.rom_addr), rom_err);
    cyc <= cyc + 1;
    if (!stall_en) stall_left <= 5;
    else if (stall_left != 0 && bus.sram_avalid && bus.sram_addr == Base + 32'd4)
      stall_left <= stall_left - 1;
  end

  assign bus.sram_ready = !(stall_en && stall_left != 0 && bus.sram_avalid &&
                            bus.sram_addr == Base + 32'd4);

  // Monitor: an accepted write seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (arst_n) begin
      if (bus.rom_avalid) rom_reqs <= rom_reqs + 1;
      if (bus.sram_avalid) sram_reqs <= sram_reqs + 1;
      if (bus.sram_avalid && bus.sram_ready)
        obs_q.push_back('{bus.sram_addr, bus.sram_wdata, bus.sram_wstrb, cyc + 1});
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_copy();
    for (int i = 0; i < int'(Words); i++)
      exp_q.push_back('{Base + 32'(i * 4), rom_word(i, rom_err), 4'hF, 0});
  endtask

  task automatic drain(input int n, output int last_cyc);
    check("sb_count", 64'(obs_q.size()), 64'(n));
    last_cyc = -1;
    for (int i = 0; i < n && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      wr_t o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check("sb_addr", 64'(o.addr), 64'(e.addr));
      check("sb_data", 64'(o.data), 64'(e.data));
      check("sb_strb", 64'(o.strb), 64'(e.strb));
      last_cyc = o.cyc;
    end
    obs_q.delete();
  endtask

  task automatic wait_run(input int budget, output int fall);
    int n = 0;
    while (cpu_reset !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("run_reached", 64'(cpu_reset), 64'(0));
    fall = cyc;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  initial begin
    int fall, last, rel, r0, s0, n;
    logic [31:0] cap_addr, cap_data;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cpu_reset", 64'(cpu_reset), 64'(1));
    check("rst_busy", 64'(busy), 64'(1));
    check("rst_err", 64'(err), 64'(0));
    check("rst_rom_avalid", 64'(bus.rom_avalid), 64'(0));
    check("rst_sram_avalid", 64'(bus.sram_avalid), 64'(0));
    check("rst_wstrb", 64'(bus.sram_wstrb), 64'(0));
    check("rst_state", 64'(dut.state_q), 64'(StIdle));

    // 1: full copy, then hold timing
    push_copy();
    arst_n = 1'b1;
    wait_run(200, fall);
    drain(int'(Words), last);
    check("t1_hold_cycles", 64'(fall - last), 64'(Hold));
    check("t1_busy", 64'(busy), 64'(0));
    check("t1_state", 64'(dut.state_q), 64'(StRun));

    // 2: no-copy boot
    @(negedge clk) arst_n = 1'b0;
    boot = 1'b0;
    @(negedge clk);
    r0 = rom_reqs;
    s0 = sram_reqs;
    arst_n = 1'b1;
    rel = cyc;
    wait_run(50, fall);
    check("t2_release", 64'(fall - rel), 64'(Hold + 1));
    check("t2_rom_reqs", 64'(rom_reqs - r0), 64'(0));
    check("t2_sram_reqs", 64'(sram_reqs - s0), 64'(0));
    drain(0, last);

    // 3: SRAM back-pressure on word 2
    @(negedge clk) arst_n = 1'b0;
    boot = 1'b1;
    stall_en = 1'b1;
    push_copy();
    @(negedge clk) arst_n = 1'b1;
    n = 0;
    while (!(bus.sram_avalid && bus.sram_addr == Base + 32'd4) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t3_word2_seen", 64'(bus.sram_addr), 64'(Base + 32'd4));
    cap_addr = bus.sram_addr;
    cap_data = bus.sram_wdata;
    repeat (4) begin
      @(negedge clk);
      check("t3_avalid_held", 64'(bus.sram_avalid), 64'(1));
      check("t3_addr_stable", 64'(bus.sram_addr), 64'(cap_addr));
      check("t3_data_stable", 64'(bus.sram_wdata), 64'(cap_data));
      check("t3_cnt_held", 64'(dut.cnt_q), 64'(1));
    end
    wait_run(200, fall);
    drain(int'(Words), last);
    check("t3_stall_used", 64'(stall_left), 64'(0));
    stall_en = 1'b0;

    // 4: reset mid-copy during word 3, start pulses ignored
    @(negedge clk) arst_n = 1'b0;
    @(negedge clk);
    push_copy();
    arst_n = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (!(bus.rom_avalid && bus.rom_addr == 4'd2) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t4_word3_seen", 64'(bus.rom_addr), 64'(2));
    drain(2, last);
    exp_q.delete();
    #2 arst_n = 1'b0;
    #1;
    check("t4_cpu_reset", 64'(cpu_reset), 64'(1));
    check("t4_busy", 64'(busy), 64'(1));
    check("t4_rom_avalid", 64'(bus.rom_avalid), 64'(0));
    check("t4_rom_addr", 64'(bus.rom_addr), 64'(0));
    check("t4_state", 64'(dut.state_q), 64'(StIdle));
    push_copy();
    @(negedge clk) arst_n = 1'b1;
    repeat (6) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_run(200, fall);
    drain(int'(Words), last);

    // 5: reboot from RUN
    push_copy();
    pulse_start();
    check("t5_cpu_reset_rise", 64'(cpu_reset), 64'(1));
    check("t5_state_idle", 64'(dut.state_q), 64'(StIdle));
    wait_run(200, fall);
    drain(int'(Words), last);
`ifdef BOOT_COPY_CHECKSUM_EN
    rom_err = 1'b1;
    push_copy();
    pulse_start();
    n = 0;
    while (err !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_err", 64'(err), 64'(1));
    check("t5_err_state", 64'(dut.state_q), 64'(StErr));
    repeat (10) @(negedge clk);
    check("t5_err_cpu_reset", 64'(cpu_reset), 64'(1));
    check("t5_err_busy", 64'(busy), 64'(0));
    drain(int'(Words), last);
    rom_err = 1'b0;
    push_copy();
    pulse_start();
    check("t5_err_cleared", 64'(err), 64'(0));
    wait_run(200, fall);
    drain(int'(Words), last);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
